// File: rtl/if_id_buf.sv
// if_id_buf: DEPTH-entry in-order instruction buffer between fetch and decode.
// It shows NOP_INST at address 0 to decode whenever it is empty or has just been flushed.
module if_id_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_WIDTH-1:0]        inst_addr_i,
  input  logic [DATA_WIDTH-1:0]        inst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [ADDR_WIDTH-1:0]        inst_addr_o,
  output logic [DATA_WIDTH-1:0]        inst_o,
  output logic                         valid_o,
  input  logic                         stall_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign ready_o = count != CW'(DEPTH);
  assign valid_o = count != '0;
  assign push = valid_i & ready_o;
  assign pop = valid_o & ~stall_i;
  assign count_o = count;
  assign inst_addr_o = valid_o ? addr_mem[rd_ptr] : '0;
  assign inst_o = valid_o ? inst_mem[rd_ptr] : NOP_INST;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Storage needs no reset: nothing reads it while count is 0.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= inst_addr_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end
endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: randomized and directed stimulus for if_id_buf.
// A queue-based reference model predicts the outputs after every clock edge.
module tb_if_id_buf;
  localparam int AW = 32, DW = 32, DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk_i = 0, rst_i = 1, valid_i = 0, stall_i = 0, flush_i = 0;
  logic [AW-1:0] inst_addr_i = '0;
  logic [DW-1:0] inst_i = '0;
  logic ready_o, valid_o;
  logic [AW-1:0] inst_addr_o;
  logic [DW-1:0] inst_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  int n_cmp = 0, n_err = 0;
  logic [63:0] q[$];
  bit seen_40 = 0;
  if_id_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
    .valid_i(valid_i), .ready_o(ready_o), .inst_addr_o(inst_addr_o), .inst_o(inst_o),
    .valid_o(valid_o), .stall_i(stall_i), .flush_i(flush_i), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic s, input logic f, input logic r, input string tag);
    bit do_push, do_pop;
    valid_i = v; inst_addr_i = a; inst_i = d; stall_i = s; flush_i = f; rst_i = r;
    do_push = v && q.size() < DEPTH;
    do_pop = !s && q.size() > 0;
    @(posedge clk_i);
    if (r || f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({a, d});
    end
    #1;
    if (valid_o && inst_addr_o == 32'h40) seen_40 = 1;
    chk({tag, ".count"}, 64'(count_o), 64'(q.size()));
    chk({tag, ".valid"}, 64'(valid_o), 64'(q.size() != 0));
    chk({tag, ".ready"}, 64'(ready_o), 64'(q.size() != DEPTH));
    chk({tag, ".addr"}, 64'(inst_addr_o), q.size() ? 64'(q[0][63:32]) : 64'h0);
    chk({tag, ".inst"}, 64'(inst_o), q.size() ? 64'(q[0][31:0]) : 64'(NOP));
  endtask
  initial begin
    step(1, 32'h500, 32'h1111, 0, 0, 1, "rst0");
    step(1, 32'h504, 32'h2222, 0, 0, 1, "rst1");
    step(1, 32'h100, 32'hAAAA0001, 0, 0, 0, "pass_push");
    chk("pass_addr", 64'(inst_addr_o), 64'h100);
    step(0, 0, 0, 0, 0, 0, "pass_drain");
    chk("pass_nop", 64'(inst_o), 64'(NOP));
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), $urandom, 1, 0, 0, "fill");
    step(1, 32'h10, $urandom, 1, 0, 0, "fill_full");
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(inst_addr_o), 64'(i * 4));
      step(0, 0, 0, 0, 0, 0, "drain");
    end
    chk("drain_empty", 64'(valid_o), 64'd0);
    step(1, 32'h200, $urandom, 1, 0, 0, "pp_pre0");
    step(1, 32'h204, $urandom, 1, 0, 0, "pp_pre1");
    for (int i = 0; i < 10; i++) begin
      chk("pp_head", 64'(inst_addr_o), 64'(32'h200 + 4 * i));
      step(1, 32'(32'h208 + 4 * i), $urandom, 0, 0, 0, "pushpop");
      chk("pp_count", 64'(count_o), 64'd2);
    end
    step(1, 32'h300, $urandom, 1, 0, 0, "fl_pre");
    chk("fl_count3", 64'(count_o), 64'd3);
    step(1, 32'h40, $urandom, 1, 1, 0, "flush");
    chk("fl_valid", 64'(valid_o), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "fl_idle");
    chk("fl_no40", 64'(seen_40), 64'd0);
    step(1, 32'h60, $urandom, 1, 0, 0, "mr_pre0");
    step(1, 32'h64, $urandom, 1, 0, 0, "mr_pre1");
    step(1, 32'h68, $urandom, 0, 0, 1, "mid_rst");
    chk("mr_count", 64'(count_o), 64'd0);
    step(1, 32'h80, 32'h8080, 0, 0, 0, "mr_push");
    chk("mr_80", 64'(inst_addr_o), 64'h80);
    step(0, 0, 0, 0, 0, 0, "mr_after");
    chk("mr_alone", 64'(valid_o), 64'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
